branch_predictor_bht: RTL and testbench



---
 rtl/branch_predictor_bht.sv | 145 ++++++++++++++
 tb/tb_branch_predictor_bht.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// ============================================================================
//  Module   : branch_predictor_bht
//  Purpose  : Per-PC saturating-counter branch predictor with a target buffer.
//             Fetch looks it up combinationally. Decode writes back resolved
//             branches, one per cycle. Optional statistics counters are
//             included when BP_STATS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor_bht #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] FetchPC,
    output logic        PredHit,
    output logic        PredTaken,
    output logic [31:0] PredTarget,
    input  logic        UpdateValid,
    input  logic [31:0] UpdatePC,
    input  logic        UpdateTaken,
    input  logic [31:0] UpdateTarget,
    input  logic        UpdatePredTaken
`ifdef BP_STATS_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CTR_W-1:0] c_ctrMax    = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctrZero   = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] c_ctrWeakNt = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] c_ctrWeakT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] c_ctrOne    = CTR_W'(1);

    // Per-entry table state
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_fetchIdx;
    logic [TAG_W-1:0] w_fetchTag;
    logic             w_fetchHit;

    logic [IDX_W-1:0] w_updIdx;
    logic [TAG_W-1:0] w_updTag;
    logic             w_updHit;
    logic [CTR_W-1:0] w_ctrCur;
    logic [CTR_W-1:0] w_ctrNext;

    logic             w_unused;

    // ------------------------------------------------------------------
    // Lookup: reads only registered state, so a same-cycle update to the
    // same entry is not visible until the following cycle.
    // ------------------------------------------------------------------
    assign w_fetchIdx = FetchPC[IDX_W+1:2];
    assign w_fetchTag = FetchPC[IDX_W+TAG_W+1:IDX_W+2];
    assign w_fetchHit = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);

    assign PredHit    = !Reset && w_fetchHit;
    assign PredTaken  = !Reset && w_fetchHit && r_ctr[w_fetchIdx][CTR_W-1];
    assign PredTarget = (!Reset && w_fetchHit) ? r_target[w_fetchIdx] : 32'h0;

    // ------------------------------------------------------------------
    // Update side
    // ------------------------------------------------------------------
    assign w_updIdx = UpdatePC[IDX_W+1:2];
    assign w_updTag = UpdatePC[IDX_W+TAG_W+1:IDX_W+2];
    assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_ctrCur = r_ctr[w_updIdx];

    always_comb begin
        w_ctrNext = w_ctrCur;
        if (UpdateTaken) begin
            if (w_ctrCur != c_ctrMax) begin
                w_ctrNext = w_ctrCur + c_ctrOne;
            end
        end else begin
            if (w_ctrCur != c_ctrZero) begin
                w_ctrNext = w_ctrCur - c_ctrOne;
            end
        end
    end

    // A not-taken miss never allocates, so aliasing entries survive it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= c_ctrWeakNt;
            end
        end else if (UpdateValid) begin
            if (w_updHit) begin
                r_ctr[w_updIdx] <= w_ctrNext;
                if (UpdateTaken) begin
                    r_target[w_updIdx] <= UpdateTarget;
                end
            end else if (UpdateTaken) begin
                r_valid[w_updIdx]  <= 1'b1;
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= UpdateTarget;
                r_ctr[w_updIdx]    <= c_ctrWeakT;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_branchCount;
    logic [31:0] r_mispredictCount;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_branchCount     <= 32'h0;
            r_mispredictCount <= 32'h0;
        end else if (UpdateValid) begin
            if (r_branchCount != 32'hFFFF_FFFF) begin
                r_branchCount <= r_branchCount + 32'd1;
            end
            if ((UpdatePredTaken != UpdateTaken) &&
                (r_mispredictCount != 32'hFFFF_FFFF)) begin
                r_mispredictCount <= r_mispredictCount + 32'd1;
            end
        end
    end

    assign BranchCount     = r_branchCount;
    assign MispredictCount = r_mispredictCount;
`endif

    // PC bits outside index/tag (and the stats-only input) are intentionally ignored.
    assign w_unused = ^{FetchPC, UpdatePC, UpdatePredTaken};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
// Testbench for branch_predictor_bht: directed checks from the test plan plus
// randomized traffic compared every cycle against a table-level model.
`default_nettype none

module tb_branch_predictor_bht;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CTR_MAX = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] FetchPC = 32'h0;
    logic        PredHit;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        UpdateValid = 1'b0;
    logic [31:0] UpdatePC = 32'h0;
    logic        UpdateTaken = 1'b0;
    logic [31:0] UpdateTarget = 32'h0;
    logic        UpdatePredTaken = 1'b0;
`ifdef BP_STATS_EN
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;
`endif

    branch_predictor_bht #(
        .ENTRIES(ENTRIES),
        .TAG_W  (TAG_W),
        .CTR_W  (CTR_W)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .FetchPC        (FetchPC),
        .PredHit        (PredHit),
        .PredTaken      (PredTaken),
        .PredTarget     (PredTarget),
        .UpdateValid    (UpdateValid),
        .UpdatePC       (UpdatePC),
        .UpdateTaken    (UpdateTaken),
        .UpdateTarget   (UpdateTarget),
        .UpdatePredTaken(UpdatePredTaken)
`ifdef BP_STATS_EN
        ,
        .BranchCount    (BranchCount),
        .MispredictCount(MispredictCount)
`endif
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: a table of entries indexed by (pc/4) mod ENTRIES.
    bit          mValid  [ENTRIES];
    int          mTag    [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCtr    [ENTRIES];
    longint      mBranches;
    longint      mMispredicts;

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tagOf(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mValid[i] = 1'b0; mTag[i] = 0; mTarget[i] = 32'h0; mCtr[i] = CTR_HALF - 1;
            end
            mBranches = 0; mMispredicts = 0;
        end else if (UpdateValid) begin
            int i;
            i = idxOf(UpdatePC);
            if (mValid[i] && mTag[i] == tagOf(UpdatePC)) begin
                if (UpdateTaken) begin
                    mCtr[i] = (mCtr[i] + 1 > CTR_MAX) ? CTR_MAX : mCtr[i] + 1;
                    mTarget[i] = UpdateTarget;
                end else begin
                    mCtr[i] = (mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1;
                end
            end else if (UpdateTaken) begin
                mValid[i] = 1'b1; mTag[i] = tagOf(UpdatePC);
                mTarget[i] = UpdateTarget; mCtr[i] = CTR_HALF;
            end
            mBranches = (mBranches < 64'hFFFF_FFFF) ? mBranches + 1 : mBranches;
            if (UpdatePredTaken != UpdateTaken)
                mMispredicts = (mMispredicts < 64'hFFFF_FFFF) ? mMispredicts + 1 : mMispredicts;
        end
    end

    // Compare process: outputs are checked mid-cycle on every falling edge.
    always @(negedge Clk) begin
        int  i;
        bit  hit;
        i = idxOf(FetchPC);
        hit = !Reset && mValid[i] && (mTag[i] == tagOf(FetchPC));
        check("model PredHit", {31'b0, PredHit}, {31'b0, hit});
        check("model PredTaken", {31'b0, PredTaken}, {31'b0, hit && (mCtr[i] >= CTR_HALF)});
        check("model PredTarget", PredTarget, hit ? mTarget[i] : 32'h0);
`ifdef BP_STATS_EN
        check("model BranchCount", BranchCount, 32'(mBranches));
        check("model MispredictCount", MispredictCount, 32'(mMispredicts));
`endif
    end

    task automatic doUpd(input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic predTaken);
        UpdatePC = pc; UpdateTaken = taken; UpdateTarget = tgt;
        UpdatePredTaken = predTaken; UpdateValid = 1'b1;
        @(posedge Clk); #1;
        UpdateValid = 1'b0;
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic expHit,
                        input logic expTaken, input logic [31:0] expTarget);
        FetchPC = pc; #1;
        check({nm, " hit"}, {31'b0, PredHit}, {31'b0, expHit});
        check({nm, " taken"}, {31'b0, PredTaken}, {31'b0, expTaken});
        check({nm, " target"}, PredTarget, expTarget);
    endtask

    initial begin
        #12 Reset = 1'b0;
        @(posedge Clk); #1;
        look("reset", 32'h40, 1'b0, 1'b0, 32'h0);

        doUpd(32'h40, 1'b1, 32'h80, 1'b0);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h80);

        doUpd(32'h40, 1'b1, 32'h80, 1'b1);
        doUpd(32'h40, 1'b1, 32'h80, 1'b1);
        doUpd(32'h40, 1'b0, 32'h999, 1'b1);
        look("sat3 then nt", 32'h40, 1'b1, 1'b1, 32'h80);
        doUpd(32'h40, 1'b0, 32'h999, 1'b1);
        look("weak nt", 32'h40, 1'b1, 1'b0, 32'h80);
        repeat (4) doUpd(32'h40, 1'b0, 32'h999, 1'b0);
        doUpd(32'h40, 1'b1, 32'h80, 1'b0);
        look("sat0 then t", 32'h40, 1'b1, 1'b0, 32'h80);
        doUpd(32'h40, 1'b1, 32'h80, 1'b0);
        look("climb", 32'h40, 1'b1, 1'b1, 32'h80);

        doUpd(32'h140, 1'b0, 32'h200, 1'b0);
        look("alias nt keeps", 32'h40, 1'b1, 1'b1, 32'h80);
        doUpd(32'h140, 1'b1, 32'h200, 1'b0);
        look("alias evicted", 32'h40, 1'b0, 1'b0, 32'h0);
        look("alias new", 32'h140, 1'b1, 1'b1, 32'h200);

        UpdatePC = 32'h44; UpdateTaken = 1'b1; UpdateTarget = 32'h300;
        UpdateValid = 1'b1; FetchPC = 32'h44; #1;
        check("same-cycle hit", {31'b0, PredHit}, 32'h0);
        @(posedge Clk); #1;
        UpdateValid = 1'b0;
        look("next-cycle", 32'h44, 1'b1, 1'b1, 32'h300);

        look("pre async", 32'h140, 1'b1, 1'b1, 32'h200);
        Reset = 1'b1;
        look("async reset", 32'h140, 1'b0, 1'b0, 32'h0);
        Reset = 1'b0;
        look("after reset", 32'h44, 1'b0, 1'b0, 32'h0);

`ifdef BP_STATS_EN
        doUpd(32'h48, 1'b1, 32'h10, 1'b1);
        doUpd(32'h48, 1'b0, 32'h10, 1'b1);
        doUpd(32'h48, 1'b1, 32'h10, 1'b1);
        check("BranchCount", BranchCount, 32'd3);
        check("MispredictCount", MispredictCount, 32'd1);
        Reset = 1'b1; #1;
        check("BranchCount reset", BranchCount, 32'd0);
        check("MispredictCount reset", MispredictCount, 32'd0);
        Reset = 1'b0;
`endif

        // Randomized phase: small index/tag pool to force hits and aliasing.
        for (int n = 0; n < 3000; n++) begin
            @(posedge Clk); #1;
            UpdateValid     = ($urandom_range(0, 9) < 6);
            UpdatePC        = {$urandom_range(0, 65535), 16'h0} |
                              32'($urandom_range(0, 2) << (IDX_W + 2)) |
                              32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            UpdateTaken     = $urandom_range(0, 1);
            UpdateTarget    = $urandom;
            UpdatePredTaken = $urandom_range(0, 1);
            FetchPC         = {$urandom_range(0, 65535), 16'h0} |
                              32'($urandom_range(0, 2) << (IDX_W + 2)) |
                              32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1; #2; Reset = 1'b0;
            end
        end
        UpdateValid = 1'b0;
        @(posedge Clk); #1;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
